// File: rtl/button_bounce_gen.sv
// button_bounce_gen: drives a single-bit button line that bounces before it
// settles. Clean press/release commands go in. A noisy but glitch-free line
// comes out for the sync/debounce/edge-detect chain. The bounce timing is
// either fixed, or drawn from a free-running 16-bit Galois LFSR.
module button_bounce_gen #(
  parameter bit          RANDOM        = 1'b0,     // 0: fixed pattern, 1: LFSR-driven
  parameter int          MAX_BOUNCES   = 3,        // 2^k-1, <= 255
  parameter int          MAX_GAP       = 4,        // power of 2, <= 256
  parameter int          SETTLE_CYCLES = 8,        // >= 1
  parameter logic [15:0] SEED          = 16'hACE1, // 0 is replaced by 1
  parameter bit          IDLE_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  input  logic cmd_press,
  output logic cmd_ready,
  output logic button_out,
  output logic busy,
  output logic done
);

  localparam logic [15:0] LFSR_INIT   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [7:0]  BOUNCE_MASK = 8'(MAX_BOUNCES);
  localparam logic [7:0]  GAP_MASK    = 8'(MAX_GAP - 1);
  // The counter holds segment lengths minus one (<= 255) and the settle time.
  localparam int          SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int          CNT_W       = (SETTLE_W > 8) ? SETTLE_W : 8;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_HI,  // target level L shown
    S_BOUNCE_LO,  // opposite level ~L shown
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             level_q, level_d;    // target level L latched at accept
  logic [7:0]       pair_q, pair_d;      // glitch pairs still to emit
  logic [7:0]       gap_q, gap_d;        // current pair's segment length minus one
  logic [CNT_W-1:0] cnt_q, cnt_d;        // cycles left in the current segment, minus one
  logic             button_q, button_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [15:0]      lfsr_q, lfsr_d;

  logic             accept;
  logic [7:0]       bounce_draw;
  logic [7:0]       gap_draw;

  assign accept      = cmd_valid && ready_q;
  // Both draws use the LFSR value present at the edge that loads them.
  assign bounce_draw = RANDOM ? (lfsr_q[15:8] & BOUNCE_MASK) : BOUNCE_MASK;
  assign gap_draw    = RANDOM ? (lfsr_q[7:0] & GAP_MASK) : GAP_MASK;

  assign button_out  = button_q;
  assign done        = done_q;
  assign cmd_ready   = ready_q;
  assign busy        = ~ready_q;

  // State, counters, LFSR and registered outputs; reset aborts any command silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      level_q  <= IDLE_LEVEL;
      pair_q   <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      button_q <= IDLE_LEVEL;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      lfsr_q   <= LFSR_INIT;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      level_q  <= level_d;
      pair_q   <= pair_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      button_q <= button_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      lfsr_q   <= lfsr_d;
    end
  end

  // Next-state logic. Outputs are computed for the next state, so they come out registered.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d  = state_q;
    level_d  = level_q;
    pair_d   = pair_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    button_d = button_q;
    done_d   = 1'b0;
    lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    unique case (state_q)
      // DONE accepts a new command exactly like IDLE does.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          level_d  = cmd_press;
          button_d = cmd_press;
          // A command to the level already shown skips the bounce.
          if ((cmd_press == button_q) || (bounce_draw == 8'd0)) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            state_d = S_BOUNCE_HI;
            pair_d  = bounce_draw;
            gap_d   = gap_draw;
            cnt_d   = CNT_W'(gap_draw);
          end
        end
      end

      S_BOUNCE_HI: begin
        if (cnt_q == '0) begin
          // The low half of a pair reuses the gap drawn for the high half.
          state_d  = S_BOUNCE_LO;
          button_d = ~level_q;
          cnt_d    = CNT_W'(gap_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_BOUNCE_LO: begin
        if (cnt_q == '0) begin
          pair_d   = pair_q - 8'd1;
          button_d = level_q;
          if (pair_q > 8'd1) begin
            state_d = S_BOUNCE_HI;
            gap_d   = gap_draw;
            cnt_d   = CNT_W'(gap_draw);
          end else begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
  end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen. A directed vector table drives the fixed-pattern
// instance. A model-checked random run drives an LFSR-driven instance.
module tb_button_bounce_gen;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          N_RND = 200;

  logic clk = 1'b0;
  logic rst0, v0, p0, r0, b0, bz0, d0;
  logic rst1, v1, p1, r1, b1, bz1, d1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  button_bounce_gen dut0 (
    .clk(clk), .reset(rst0), .cmd_valid(v0), .cmd_press(p0),
    .cmd_ready(r0), .button_out(b0), .busy(bz0), .done(d0)
  );

  button_bounce_gen #(.RANDOM(1'b1), .MAX_BOUNCES(7), .MAX_GAP(8)) dut1 (
    .clk(clk), .reset(rst1), .cmd_valid(v1), .cmd_press(p1),
    .cmd_ready(r1), .button_out(b1), .busy(bz1), .done(d1)
  );

  typedef struct {
    logic valid;
    logic press;
    logic btn;
    logic rdy;
    logic dn;
    int   reps;
  } vec_t;

  vec_t vecs[$];
  bit   rnd_press[N_RND];
  int   rnd_idle[N_RND];
  bit   exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic p, input logic b,
                              input logic r, input logic d, input int n);
    vec_t e;
    e.valid = v; e.press = p; e.btn = b; e.rdy = r; e.dn = d; e.reps = n;
    vecs.push_back(e);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ({1'b0, x[15:1]} ^ 16'hB400) : {1'b0, x[15:1]};
  endfunction

  // Reference LFSR that runs alongside the random instance.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst1)
    if (rst1) m_lfsr <= SEED;
    else      m_lfsr <= lfsr_step(m_lfsr);

  // Expected button levels for cycles 1..N after an accept. s is the LFSR value at the accept edge.
  function automatic void build_expect(input logic [15:0] s, input bit lvl, input bit cur);
    logic [15:0] l = s;
    int pairs;
    int g;
    exp_q.delete();
    pairs = (lvl == cur) ? 0 : int'(s[15:8] & 8'h07);
    for (int p = 0; p < pairs; p++) begin
      g = int'(l[7:0] & 8'h07) + 1;
      for (int c = 0; c < 2 * g; c++) begin
        exp_q.push_back((c < g) ? lvl : ~lvl);
        l = lfsr_step(l);
      end
    end
    repeat (8) exp_q.push_back(lvl);
  endfunction

  task automatic apply_rows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      for (int n = 0; n < vecs[r].reps; n++) begin
        v0 = vecs[r].valid;
        p0 = vecs[r].press;
        @(negedge clk);
        check($sformatf("vec %0d.%0d {btn,rdy,busy,done}", r, n),
              {28'd0, b0, r0, bz0, d0},
              {28'd0, vecs[r].btn, vecs[r].rdy, ~vecs[r].rdy, vecs[r].dn});
      end
    end
    v0 = 1'b0;
    p0 = 1'b0;
  endtask

  task automatic reset_rnd();
    rst1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0;
  endtask

  task automatic run_random(output int unsigned sig);
    bit cur = 1'b0;
    bit bp  = 1'b0;
    int errs, viol, run_len, trans, n;
    sig = 32'h1505;
    for (int k = 0; k < N_RND; k++) begin
      errs = 0;
      for (int i = 0; i < rnd_idle[k]; i++) begin
        @(negedge clk);
        if (b1 !== cur || r1 !== 1'b1 || bz1 !== 1'b0 || d1 !== 1'b0) errs++;
        sig = (sig * 33) ^ {29'd0, b1, r1, d1};
      end
      build_expect(m_lfsr, rnd_press[k], cur);
      n = exp_q.size();
      v1 = 1'b1;
      p1 = rnd_press[k];
      viol = 0; run_len = 0; trans = 0;
      for (int i = 0; i <= n; i++) begin
        @(negedge clk);
        v1 = 1'b0;
        p1 = 1'b0;
        sig = (sig * 33) ^ {29'd0, b1, r1, d1};
        if (i < n) begin
          if (b1 !== exp_q[i] || r1 !== 1'b0 || bz1 !== 1'b1 || d1 !== 1'b0) errs++;
          // Observed shape: every bounce segment is at most 8 cycles, with at most 7 pairs.
          if (i > 0 && b1 !== bp) begin
            if (run_len > 8) viol++;
            trans++;
            run_len = 1;
          end else begin
            run_len++;
          end
          bp = b1;
        end else begin
          if (b1 !== rnd_press[k] || r1 !== 1'b1 || bz1 !== 1'b0 || d1 !== 1'b1) errs++;
        end
      end
      if (trans > 14) viol++;
      check($sformatf("rnd cmd %0d trace mismatches", k), errs, 0);
      check($sformatf("rnd cmd %0d shape violations", k), viol, 0);
      check($sformatf("rnd cmd %0d final level", k), {31'd0, b1}, {31'd0, rnd_press[k]});
      cur = rnd_press[k];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned sig_a;
    int unsigned sig_b;
    int dn_seen;
    int bad_seen;

    rst0 = 1'b1; rst1 = 1'b1;
    v0 = 1'b0; p0 = 1'b0; v1 = 1'b0; p1 = 1'b0;

    // Rows 0-9: press from level 0. H 1-4, L 5-8, H 9-12, L 13-16, H 17-20, L 21-24, H 25-32, done 33.
    add(1, 1, 1, 0, 0, 1); add(0, 0, 1, 0, 0, 3); add(0, 0, 0, 0, 0, 4);
    add(0, 0, 1, 0, 0, 4); add(0, 0, 0, 0, 0, 4); add(0, 0, 1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 4); add(0, 0, 1, 0, 0, 8); add(0, 0, 1, 1, 1, 1);
    add(0, 0, 1, 1, 0, 2);
    // Rows 10-11: same-level press, with valid held while busy. Level 1 for 8 cycles, done in cycle 9.
    add(1, 1, 1, 0, 0, 8); add(0, 0, 1, 1, 1, 1);
    // Rows 12-21: release, accepted in the DONE cycle. Mirror-image pattern.
    add(1, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 3); add(0, 0, 1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 4); add(0, 0, 1, 0, 0, 4); add(0, 0, 0, 0, 0, 4);
    add(0, 0, 1, 0, 0, 4); add(0, 0, 0, 0, 0, 8); add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 0, 2);
    // Rows 22-34: press, with a stray release command around cycle 10 that must be ignored.
    add(1, 1, 1, 0, 0, 1); add(0, 0, 1, 0, 0, 3); add(0, 0, 0, 0, 0, 4);
    add(0, 0, 1, 0, 0, 1); add(1, 0, 1, 0, 0, 1); add(1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1); add(0, 0, 0, 0, 0, 4); add(0, 0, 1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 4); add(0, 0, 1, 0, 0, 8); add(0, 0, 1, 1, 1, 1);
    add(0, 0, 1, 1, 0, 2);

    for (int k = 0; k < N_RND; k++) begin
      rnd_press[k] = bit'($urandom_range(0, 1));
      rnd_idle[k]  = int'($urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    check("reset dut0 {btn,rdy,busy,done}", {28'd0, b0, r0, bz0, d0}, 32'b0100);
    check("reset dut1 {btn,rdy,busy,done}", {28'd0, b1, r1, bz1, d1}, 32'b0100);

    apply_rows(0, 34);

    // Release from 1, then reset asynchronously in the middle of BOUNCE_LO (cycle 6).
    v0 = 1'b1; p0 = 1'b0;
    @(negedge clk);
    v0 = 1'b0;
    check("abort c1 btn", {31'd0, b0}, 32'd0);
    repeat (5) @(negedge clk);
    check("abort c6 {btn,rdy}", {30'd0, b0, r0}, 32'b10);
    #2 rst0 = 1'b1;
    #1;
    check("async reset {btn,rdy,busy,done}", {28'd0, b0, r0, bz0, d0}, 32'b0100);
    @(negedge clk);
    rst0 = 1'b0;
    dn_seen = 0;
    bad_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (d0 !== 1'b0) dn_seen++;
      if (b0 !== 1'b0 || r0 !== 1'b1) bad_seen++;
    end
    check("no done after abort", dn_seen, 0);
    check("idle after abort", bad_seen, 0);
    apply_rows(0, 9);

    // First random run.
    reset_rnd();
    run_random(sig_a);

    // Abort a command mid-flight, then replay. The LFSR must restart from SEED.
    v1 = 1'b1; p1 = ~b1;
    @(negedge clk);
    v1 = 1'b0; p1 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst1 = 1'b1;
    #1;
    check("rnd async reset {btn,rdy,busy,done}", {28'd0, b1, r1, bz1, d1}, 32'b0100);
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    run_random(sig_b);
    check("replay trace signature", sig_b, sig_a);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
